// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the RAM port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_DBG
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and debug requesters.
// MEM_ARB_RR_EN selects round-robin; otherwise debug has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dbg_req,
    input  owner_e last_owner,
    output logic   grant_valid,
    output owner_e grant_owner
);

    assign grant_valid = cpu_req | dbg_req;

`ifdef MEM_ARB_RR_EN
    // On a collision the requester that did not own the previous access wins.
    assign grant_owner = (dbg_req && (!cpu_req || last_owner == OWN_CPU)) ? OWN_DBG : OWN_CPU;
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign grant_owner       = dbg_req ? OWN_DBG : OWN_CPU;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the CPU path and the serial debug/loader port.
// Build with MEM_ARB_RR_EN for round-robin arbitration instead of debug priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reg_clear,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_wait,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned CNT_W = 2;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_we_q, cmd_we_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic   grant_valid;
    owner_e grant_owner;
    logic   cpu_hit;
    logic   dbg_hit;

    mem_arb_pick u_pick (
        .cpu_req     (cpu_req),
        .dbg_req     (dbg_req),
        .last_owner  (owner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // RAM data arrives in the ack cycle, so it is forwarded straight through
    // while the register keeps the value for the cycles after.
    assign cpu_hit   = (state_q == RESP) && (owner_q == OWN_CPU) && !cmd_we_q;
    assign dbg_hit   = (state_q == RESP) && (owner_q == OWN_DBG) && !cmd_we_q;
    assign cpu_rdata = cpu_hit ? ram_rdata : cpu_rdata_q;
    assign dbg_rdata = dbg_hit ? ram_rdata : dbg_rdata_q;

    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_wait  = cpu_req & ~cpu_ack_q & ~reg_clear;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

    always_ff @(posedge clk or posedge reg_clear) begin
        if (reg_clear) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            cnt_q       <= '0;
            cmd_we_q    <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            cmd_we_q    <= cmd_we_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        cmd_we_d    = cmd_we_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d  = ACCESS;
                    owner_d  = grant_owner;
                    ram_en_d = 1'b1;
                    if (grant_owner == OWN_DBG) begin
                        cmd_we_d    = dbg_we;
                        ram_we_d    = dbg_we;
                        ram_addr_d  = dbg_addr;
                        ram_wdata_d = dbg_wdata;
                    end else begin
                        cmd_we_d    = cpu_we;
                        ram_we_d    = cpu_we;
                        ram_addr_d  = cpu_addr;
                        ram_wdata_d = cpu_wdata;
                    end
                end
            end
            ACCESS: begin
                cnt_d = CNT_W'(RD_LAT - 1);
                if (RD_LAT == 1) begin
                    state_d   = RESP;
                    cpu_ack_d = (owner_q == OWN_CPU);
                    dbg_ack_d = (owner_q == OWN_DBG);
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = RESP;
                    cpu_ack_d = (owner_q == OWN_CPU);
                    dbg_ack_d = (owner_q == OWN_DBG);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                if (cpu_hit) cpu_rdata_d = ram_rdata;
                if (dbg_hit) dbg_rdata_d = ram_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (RD_LAT 1, 3, 4) each with a RAM model,
// a vector table, hand-written corner sequences and a randomized scoreboard run.
module tb_mem_arbiter;

    localparam int NDUT = 3;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    function automatic int unsigned lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    logic       clk = 1'b0;
    logic       reg_clear;
    logic       ram_init;
    int         cyc = 0;

    logic       cpu_req   [NDUT];
    logic       cpu_we    [NDUT];
    logic [7:0] cpu_addr  [NDUT];
    logic [7:0] cpu_wdata [NDUT];
    logic       cpu_ack   [NDUT];
    logic [7:0] cpu_rdata [NDUT];
    logic       cpu_wait  [NDUT];
    logic       dbg_req   [NDUT];
    logic       dbg_we    [NDUT];
    logic [7:0] dbg_addr  [NDUT];
    logic [7:0] dbg_wdata [NDUT];
    logic       dbg_ack   [NDUT];
    logic [7:0] dbg_rdata [NDUT];
    logic       ram_en    [NDUT];
    logic       ram_we    [NDUT];
    logic [7:0] ram_addr  [NDUT];
    logic [7:0] ram_wdata [NDUT];
    logic [7:0] ram_rdata [NDUT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LAT = lat_of(g);
        logic [7:0] mem  [256];
        logic [7:0] pipe [LAT];

        mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(LAT)) u_dut (
            .clk       (clk),
            .reg_clear (reg_clear),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_ack   (cpu_ack[g]),
            .cpu_rdata (cpu_rdata[g]),
            .cpu_wait  (cpu_wait[g]),
            .dbg_req   (dbg_req[g]),
            .dbg_we    (dbg_we[g]),
            .dbg_addr  (dbg_addr[g]),
            .dbg_wdata (dbg_wdata[g]),
            .dbg_ack   (dbg_ack[g]),
            .dbg_rdata (dbg_rdata[g]),
            .ram_en    (ram_en[g]),
            .ram_we    (ram_we[g]),
            .ram_addr  (ram_addr[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_rdata (ram_rdata[g])
        );

        // Synchronous RAM with LAT-cycle read pipeline.
        always @(posedge clk) begin
            if (ram_init) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
            end else if (ram_en[g] && ram_we[g]) begin
                mem[ram_addr[g]] <= ram_wdata[g];
            end
            pipe[0] <= ram_en[g] ? mem[ram_addr[g]] : 8'h00;
            for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
        end
        assign ram_rdata[g] = pipe[LAT-1];
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] shadow      [NDUT][256];
    logic [7:0] last_rd_cpu [NDUT];
    logic [7:0] last_rd_dbg [NDUT];
    bit         last_dbg    [NDUT];

    typedef struct {
        bit         dbg;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs(input int d);
        return 64'({ram_en[d], ram_we[d], ram_addr[d], ram_wdata[d], cpu_ack[d], dbg_ack[d],
                    cpu_rdata[d], dbg_rdata[d], cpu_wait[d]});
    endfunction

    task automatic drive(input int d, input bit dbg, input bit req, input bit we,
                         input logic [7:0] a, input logic [7:0] wd);
        if (dbg) begin
            dbg_req[d] = req; dbg_we[d] = we; dbg_addr[d] = a; dbg_wdata[d] = wd;
        end else begin
            cpu_req[d] = req; cpu_we[d] = we; cpu_addr[d] = a; cpu_wdata[d] = wd;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            last_rd_cpu[d] = 8'h00;
            last_rd_dbg[d] = 8'h00;
            last_dbg[d]    = 1'b0;
        end
    endtask

    // Single uncontended transaction with cycle-exact checks; starts and ends in an IDLE cycle.
    task automatic xact(input int d, input bit dbg, input bit we, input logic [7:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input string nm,
                        output int t_en);
        int         lat;
        logic [7:0] exp_use;
        lat = int'(lat_of(d));
        exp_use = we ? (dbg ? last_rd_dbg[d] : last_rd_cpu[d]) : exp_rd;
        drive(d, dbg, 1'b1, we, addr, wd);
        step();
        t_en = cyc;
        chk({nm, " cmd"}, 64'({ram_en[d], ram_we[d], ram_addr[d], ram_wdata[d], cpu_ack[d], dbg_ack[d]}),
            64'({1'b1, we, addr, wd, 2'b00}));
        if (!dbg) chk({nm, " wait_hi"}, 64'(cpu_wait[d]), 64'(1));
        for (int k = 1; k < lat; k++) begin
            step();
            chk({nm, " lat"}, 64'({ram_en[d], cpu_ack[d], dbg_ack[d]}), 64'(0));
        end
        step();
        chk({nm, " ack"}, 64'({cpu_ack[d], dbg_ack[d], dbg ? dbg_rdata[d] : cpu_rdata[d]}),
            64'({~dbg, dbg, exp_use}));
        if (!dbg) chk({nm, " wait_lo"}, 64'(cpu_wait[d]), 64'(0));
        drive(d, dbg, 1'b0, we, addr, wd);
        if (we) shadow[d][addr] = wd;
        else if (dbg) last_rd_dbg[d] = exp_rd;
        else last_rd_cpu[d] = exp_rd;
        last_dbg[d] = dbg;
        step();
        chk({nm, " idle"}, 64'({ram_en[d], cpu_ack[d], dbg_ack[d]}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        int   t1, t2, acks, n;
        bit   timeout;

        tbl[0] = '{1'b0, 1'b1, 8'h3C, 8'hA5, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5};
        tbl[2] = '{1'b1, 1'b1, 8'h80, 8'hC3, 8'h00};
        tbl[3] = '{1'b0, 1'b0, 8'h80, 8'h00, 8'hC3};
        tbl[4] = '{1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5};
        tbl[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h5A};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hA5};
        tbl[7] = '{1'b0, 1'b1, 8'h3D, 8'h11, 8'h00};

        for (int d = 0; d < NDUT; d++) begin
            drive(d, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            drive(d, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
            for (int a = 0; a < 256; a++) shadow[d][a] = init_val(8'(a));
        end
        model_reset();
        reg_clear = 1'b1;
        ram_init  = 1'b1;
        cpu_req[0] = 1'b1;
        step();
        step();
        for (int d = 0; d < NDUT; d++) chk("reset_outs", outs(d), 64'(0));
        cpu_req[0] = 1'b0;
        ram_init   = 1'b0;
        reg_clear  = 1'b0;
        step();

        // Vector table on the RD_LAT=1 instance.
        for (int i = 0; i < 8; i++)
            xact(0, tbl[i].dbg, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].exp, $sformatf("tbl%0d", i), t1);

        // Single collision: debug first, CPU after.
        drive(0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        drive(0, 1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
        step();
        chk("col_first", 64'({ram_en[0], ram_addr[0], cpu_wait[0]}), 64'({1'b1, 8'h20, 1'b1}));
        step();
        chk("col_dbg_ack", 64'({cpu_ack[0], dbg_ack[0], dbg_rdata[0], cpu_wait[0]}), 64'({2'b01, 8'h85, 1'b1}));
        dbg_req[0] = 1'b0;
        step();
        chk("col_idle", 64'({ram_en[0], cpu_wait[0]}), 64'({1'b0, 1'b1}));
        step();
        chk("col_second", 64'({ram_en[0], ram_addr[0], cpu_wait[0]}), 64'({1'b1, 8'h10, 1'b1}));
        step();
        chk("col_cpu_ack", 64'({cpu_ack[0], dbg_ack[0], cpu_rdata[0], cpu_wait[0]}), 64'({2'b10, 8'hB5, 1'b0}));
        cpu_req[0] = 1'b0;
        last_rd_dbg[0] = 8'h85;
        last_rd_cpu[0] = 8'hB5;
        last_dbg[0]    = 1'b0;
        step();

        // Four collisions with both requests held throughout.
        drive(0, 1'b0, 1'b1, 1'b0, 8'h11, 8'h00);
        drive(0, 1'b1, 1'b1, 1'b0, 8'h21, 8'h00);
        for (int i = 0; i < 4; i++) begin
            bit w;
            w = RR ? !last_dbg[0] : 1'b1;
            n = 0;
            do begin step(); n++; end while (!(cpu_ack[0] || dbg_ack[0]) && n < 10);
            chk($sformatf("alt%0d_grant", i), 64'({cpu_ack[0], dbg_ack[0]}), 64'({~w, w}));
            chk($sformatf("alt%0d_data", i), 64'(w ? dbg_rdata[0] : cpu_rdata[0]),
                64'(w ? shadow[0][8'h21] : shadow[0][8'h11]));
            if (w) last_rd_dbg[0] = shadow[0][8'h21];
            else last_rd_cpu[0] = shadow[0][8'h11];
            last_dbg[0] = w;
        end
        cpu_req[0] = 1'b0;
        dbg_req[0] = 1'b0;
        step();

        // RD_LAT=4: three wait cycles and a six-cycle access period.
        xact(2, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h5A, "lat4_a", t1);
        xact(2, 1'b0, 1'b0, 8'h05, 8'h00, 8'hA0, "lat4_b", t2);
        chk("lat4_period", 64'(t2 - t1), 64'(6));

        // Address change after latch and request dropped mid-wait.
        drive(2, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00);
        step();
        chk("latch_access", 64'({ram_en[2], ram_addr[2]}), 64'({1'b1, 8'h01}));
        dbg_addr[2] = 8'h02;
        step();
        chk("latch_wait1", 64'({ram_en[2], ram_addr[2]}), 64'({1'b0, 8'h01}));
        step();
        dbg_req[2] = 1'b0;
        step();
        chk("drop_wait3", 64'({dbg_ack[2], ram_en[2]}), 64'(0));
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) chk("drop_ack", 64'({dbg_ack[2], dbg_rdata[2]}), 64'({1'b1, 8'hA4}));
            acks += int'(dbg_ack[2]) + int'(cpu_ack[2]) + int'(ram_en[2]);
        end
        chk("drop_single_ack", 64'(acks), 64'(1));
        last_rd_dbg[2] = 8'hA4;
        last_dbg[2]    = 1'b1;

        // Asynchronous reset while a CPU read sits in WAIT on the RD_LAT=3 instance.
        drive(1, 1'b0, 1'b1, 1'b0, 8'h40, 8'h00);
        step();
        step();
        chk("rst_pre_wait", 64'({ram_en[1], cpu_ack[1], cpu_wait[1]}), 64'({1'b0, 1'b0, 1'b1}));
        reg_clear = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) chk("rst_async", outs(d), 64'(0));
        cpu_req[1] = 1'b0;
        step();
        step();
        reg_clear = 1'b0;
        model_reset();
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            acks += int'(cpu_ack[1]) + int'(dbg_ack[1]) + int'(ram_en[1]);
        end
        chk("rst_no_ack", 64'(acks), 64'(0));
        xact(1, 1'b0, 1'b0, 8'h40, 8'h00, 8'hE5, "rst_after", t1);

        // Randomized contention against the scoreboard.
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 30; r++) begin
                bit         pc, pd, cwe, dwe;
                logic [7:0] ca, cw, da, dw;
                pc = 1'($urandom);
                pd = 1'($urandom);
                if (!pc && !pd) pc = 1'b1;
                cwe = 1'($urandom); ca = 8'($urandom_range(0, 15)); cw = 8'($urandom);
                dwe = 1'($urandom); da = 8'($urandom_range(0, 15)); dw = 8'($urandom);
                drive(d, 1'b0, pc, cwe, ca, cw);
                drive(d, 1'b1, pd, dwe, da, dw);
                timeout = 1'b0;
                while ((pc || pd) && !timeout) begin
                    bit         w, wwe;
                    logic [7:0] wa, ww, exp;
                    w   = pd && (!pc || !RR || !last_dbg[d]);
                    wwe = w ? dwe : cwe;
                    wa  = w ? da : ca;
                    ww  = w ? dw : cw;
                    n = 0;
                    do begin step(); n++; end while (!(cpu_ack[d] || dbg_ack[d]) && n < 10);
                    if (n >= 10) begin
                        chk("rand_timeout", 64'(0), 64'(1));
                        timeout = 1'b1;
                    end else begin
                        exp = wwe ? (w ? last_rd_dbg[d] : last_rd_cpu[d]) : shadow[d][wa];
                        chk($sformatf("rand%0d_%0d", d, r),
                            64'({cpu_ack[d], dbg_ack[d], w ? dbg_rdata[d] : cpu_rdata[d]}),
                            64'({~w, w, exp}));
                        if (wwe) shadow[d][wa] = ww;
                        else if (w) last_rd_dbg[d] = exp;
                        else last_rd_cpu[d] = exp;
                        last_dbg[d] = w;
                        if (w) begin pd = 1'b0; dbg_req[d] = 1'b0; end
                        else begin pc = 1'b0; cpu_req[d] = 1'b0; end
                        step();
                    end
                end
                if (timeout) begin
                    cpu_req[d] = 1'b0;
                    dbg_req[d] = 1'b0;
                    for (int k = 0; k < 8; k++) step();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
